layer_laser_anim: RTL and testbench

LAYER_LASER_ANIM -- requirements
Module: layer_laser_anim

---
 rtl/laser_pkg.sv | 28 ++
 rtl/laser_anim_fsm.sv | 133 +++++++++++++
 rtl/layer_laser_anim.sv | 87 ++++++++
 tb/tb_layer_laser_anim.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared types and constants for the laser-beam overlay layer.
// Optional HOLD flash is enabled by defining LASER_FLASH_EN.
package laser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXTEND  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RETRACT = 2'd3
  } laser_state_e;

  localparam logic [11:0] COL_BEAM    = 12'h48F;
  localparam logic [11:0] COL_RETRACT = 12'h246;
  localparam logic [11:0] COL_FLASH   = 12'hFFF;

  localparam int Y_W = 11;

  localparam int DEF_VGA_XRES    = 640;
  localparam int DEF_VGA_YRES    = 480;
  localparam int DEF_BASE_Y      = 400;
  localparam int DEF_R_STEP      = 15;
  localparam int DEF_BEAM_X      = 320;
  localparam int DEF_BEAM_HALF_W = 20;
  localparam int DEF_FRAME_W     = 20;
  localparam int DEF_EXTEND_STEP = 16;
  localparam int DEF_HOLD_FRAMES = 8;

endpackage

// File: rtl/laser_anim_fsm.sv
// Laser animation sequencer: beam head position, hold timer and fire latches.
// LASER_FLASH_EN adds a phase bit toggled on every frame tick while holding.
module laser_anim_fsm
  import laser_pkg::*;
#(
  parameter int R_BITS      = 3,
  parameter int QB          = 2,
  parameter int VGA_YRES    = DEF_VGA_YRES,
  parameter int BASE_Y      = DEF_BASE_Y,
  parameter int R_STEP      = DEF_R_STEP,
  parameter int EXTEND_STEP = DEF_EXTEND_STEP,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              fire,
  input  logic [R_BITS-1:0] fire_r,
  input  logic [QB-1:0]     fire_quadrant,
  output logic [1:0]        state,
  output logic [Y_W-1:0]    head_y,
  output logic [QB-1:0]     quad,
  output logic              phase
);

  localparam int HC_W = $clog2(HOLD_FRAMES) + 1;
  localparam logic [Y_W-1:0]        YRES_Y   = Y_W'(VGA_YRES);
  localparam logic [Y_W-1:0]        BASE_Y_Y = Y_W'(BASE_Y);
  localparam logic [Y_W-1:0]        R_STEP_Y = Y_W'(R_STEP);
  localparam logic signed [Y_W:0]   STEP_S   = (Y_W+1)'(EXTEND_STEP);
  localparam logic [HC_W-1:0]       HOLD_LAST = HC_W'(HOLD_FRAMES - 1);

  laser_state_e       state_q, state_d;
  logic [Y_W-1:0]     head_y_q, head_y_d;
  logic [Y_W-1:0]     end_y_q, end_y_d;
  logic [QB-1:0]      quad_q, quad_d;
  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic signed [Y_W:0] head_dec;
  logic [Y_W:0]       head_inc;
  logic [Y_W-1:0]     end_y_new;

  // One extra bit on the step arithmetic keeps underflow/overflow visible to the clamps.
  assign head_dec  = $signed({1'b0, head_y_q}) - STEP_S;
  assign head_inc  = {1'b0, head_y_q} + Y_W'(EXTEND_STEP);
  assign end_y_new = BASE_Y_Y - Y_W'(fire_r) * R_STEP_Y;

  always_comb begin
    state_d    = state_q;
    head_y_d   = head_y_q;
    end_y_d    = end_y_q;
    quad_d     = quad_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          end_y_d  = end_y_new;
          quad_d   = fire_quadrant;
          head_y_d = YRES_Y;
          state_d  = ST_EXTEND;
        end
      end
      ST_EXTEND: begin
        if (frame_tick) begin
          if (head_dec <= $signed({1'b0, end_y_q})) begin
            head_y_d   = end_y_q;
            hold_cnt_d = '0;
            state_d    = ST_HOLD;
          end else begin
            head_y_d = head_dec[Y_W-1:0];
          end
        end
      end
      ST_HOLD: begin
        if (frame_tick) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (hold_cnt_q == HOLD_LAST) state_d = ST_RETRACT;
        end
      end
      ST_RETRACT: begin
        if (frame_tick) begin
          if (head_inc >= {1'b0, YRES_Y}) begin
            head_y_d = YRES_Y;
            state_d  = ST_IDLE;
          end else begin
            head_y_d = head_inc[Y_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // end_y reset value is the radius-0 target, matching a cleared radius latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      head_y_q   <= YRES_Y;
      end_y_q    <= BASE_Y_Y;
      quad_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      head_y_q   <= head_y_d;
      end_y_q    <= end_y_d;
      quad_q     <= quad_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

`ifdef LASER_FLASH_EN
  logic phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (state_q == ST_IDLE && fire) phase_d = 1'b0;
    else if (state_q == ST_HOLD && frame_tick) phase_d = ~phase_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= 1'b0;
    else     phase_q <= phase_d;
  end

  assign phase = phase_q;
`else
  assign phase = 1'b0;
`endif

  assign state  = state_q;
  assign head_y = head_y_q;
  assign quad   = quad_q;

endmodule

// File: rtl/layer_laser_anim.sv
// Laser overlay layer: sequencer plus per-pixel beam/frame hit test and colouring.
// Define LASER_FLASH_EN to flash the beam white on alternate HOLD frames.
module layer_laser_anim
  import laser_pkg::*;
#(
  parameter int QUADRANT      = 0,
  parameter int NUM_QUADRANTS = 4,
  parameter int R_BITS        = 3,
  parameter int VGA_XRES      = DEF_VGA_XRES,
  parameter int VGA_YRES      = DEF_VGA_YRES,
  parameter int BASE_Y        = DEF_BASE_Y,
  parameter int R_STEP        = DEF_R_STEP,
  parameter int BEAM_X        = DEF_BEAM_X,
  parameter int BEAM_HALF_W   = DEF_BEAM_HALF_W,
  parameter int FRAME_W       = DEF_FRAME_W,
  parameter int EXTEND_STEP   = DEF_EXTEND_STEP,
  parameter int HOLD_FRAMES   = DEF_HOLD_FRAMES,
  localparam int QB           = (NUM_QUADRANTS > 1) ? $clog2(NUM_QUADRANTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              fire,
  input  logic [R_BITS-1:0] fire_r,
  input  logic [QB-1:0]     fire_quadrant,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  output logic              busy,
  output logic              layer_valid,
  output logic [11:0]       pixel_out
);

  localparam logic [QB-1:0] QUAD_IDX = QB'(QUADRANT);
  localparam logic [9:0] BEAM_LO  = 10'(BEAM_X - BEAM_HALF_W);
  localparam logic [9:0] BEAM_HI  = 10'(BEAM_X + BEAM_HALF_W);
  localparam logic [9:0] FRAME_L  = 10'(FRAME_W);
  localparam logic [9:0] FRAME_RX = 10'(VGA_XRES - FRAME_W);
  localparam logic [9:0] FRAME_BY = 10'(VGA_YRES - FRAME_W);

  logic [1:0]     state_raw;
  laser_state_e   state;
  logic [Y_W-1:0] head_y;
  logic [QB-1:0]  quad;
  logic           phase;
  logic           beam_hit, frame_hit, active;

  laser_anim_fsm #(
    .R_BITS      (R_BITS),
    .QB          (QB),
    .VGA_YRES    (VGA_YRES),
    .BASE_Y      (BASE_Y),
    .R_STEP      (R_STEP),
    .EXTEND_STEP (EXTEND_STEP),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_fsm (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .fire          (fire),
    .fire_r        (fire_r),
    .fire_quadrant (fire_quadrant),
    .state         (state_raw),
    .head_y        (head_y),
    .quad          (quad),
    .phase         (phase)
  );

  assign state = laser_state_e'(state_raw);
  assign busy  = (state != ST_IDLE);

  // Purely combinational hit test so the layer lines up with the current pixel.
  assign beam_hit  = ({1'b0, v_cnt} >= head_y) && (h_cnt >= BEAM_LO) && (h_cnt <= BEAM_HI);
  assign frame_hit = (h_cnt < FRAME_L) || (h_cnt >= FRAME_RX) ||
                     (v_cnt < FRAME_L) || (v_cnt >= FRAME_BY);
  assign active    = busy && (quad == QUAD_IDX);

  always_comb begin
    layer_valid = active && (beam_hit || frame_hit);
    pixel_out   = 12'h000;
    if (layer_valid) begin
      if (state == ST_RETRACT) pixel_out = COL_RETRACT;
      else if (phase && beam_hit && state == ST_HOLD) pixel_out = COL_FLASH;
      else pixel_out = COL_BEAM;
    end
  end

endmodule

// File: tb/tb_layer_laser_anim.sv
// Scoreboard bench for layer_laser_anim: probes queue expectations, a negedge monitor checks them.
module tb_layer_laser_anim;

`ifdef LASER_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, frame_tick, fire;
  logic [2:0]  fire_r;
  logic [1:0]  fire_quadrant;
  logic [9:0]  h_cnt, v_cnt;
  logic        busy, layer_valid;
  logic [11:0] pixel_out;

  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic        busy;
    logic        vld;
    logic [11:0] pix;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  layer_laser_anim dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .fire          (fire),
    .fire_r        (fire_r),
    .fire_quadrant (fire_quadrant),
    .h_cnt         (h_cnt),
    .v_cnt         (v_cnt),
    .busy          (busy),
    .layer_valid   (layer_valid),
    .pixel_out     (pixel_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      check({cur.tag, "_busy"}, 32'(busy), 32'(cur.busy));
      check({cur.tag, "_vld"},  32'(layer_valid), 32'(cur.vld));
      check({cur.tag, "_pix"},  32'(pixel_out), 32'(cur.pix));
    end
  end

  task automatic probe(input string tag, input int h, input int v,
                       input logic eb, input logic ev, input logic [11:0] ep);
    exp_t e;
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    e.tag = tag; e.busy = eb; e.vld = ev; e.pix = ep;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic do_fire(input int r, input int q, input bit with_tick);
    fire_r        = 3'(r);
    fire_quadrant = 2'(q);
    fire          = 1'b1;
    frame_tick    = with_tick;
    @(posedge clk); #1;
    fire       = 1'b0;
    frame_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int head;
    logic [11:0] col;
    rst = 1'b1; fire = 1'b0; frame_tick = 1'b0;
    fire_r = '0; fire_quadrant = '0; h_cnt = '0; v_cnt = '0;
    @(posedge clk); #1;
    probe("reset", 5, 5, 1'b0, 1'b0, 12'h000);
    rst = 1'b0;

    // r=0, q=0: full extend / hold / retract cycle
    do_fire(0, 0, 1'b0);
    probe("a_ext_frame", 5, 5, 1'b1, 1'b1, 12'h48F);
    probe("a_ext_nobeam", 320, 450, 1'b1, 1'b0, 12'h000);
    for (int k = 1; k <= 5; k++) begin
      tick();
      head = 480 - 16 * k;
      if (head < 460) begin
        probe("a_head_on", 320, head, 1'b1, 1'b1, 12'h48F);
        probe("a_head_off", 320, head - 1, 1'b1, 1'b0, 12'h000);
      end
    end
    probe("a_hold", 320, 450, 1'b1, 1'b1, 12'h48F);
    probe("a_hold_edge", 300, 420, 1'b1, 1'b1, 12'h48F);
    probe("a_hold_out", 299, 420, 1'b1, 1'b0, 12'h000);
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t < 8) begin
        col = (FLASH && (t % 2 == 1)) ? 12'hFFF : 12'h48F;
        probe("a_hold_col", 320, 450, 1'b1, 1'b1, col);
      end
    end
    probe("a_ret_col", 320, 470, 1'b1, 1'b1, 12'h246);
    probe("a_ret_beam", 320, 410, 1'b1, 1'b1, 12'h246);
    for (int k = 1; k <= 5; k++) begin
      tick();
      head = 400 + 16 * k;
      if (head <= 460) begin
        probe("a_ret_on", 320, head, 1'b1, 1'b1, 12'h246);
        probe("a_ret_off", 320, head - 1, 1'b1, 1'b0, 12'h000);
      end
    end
    probe("a_idle", 320, 470, 1'b0, 1'b0, 12'h000);
    probe("a_idle_frame", 5, 5, 1'b0, 1'b0, 12'h000);

    // r=7: end_y = 295, clamped on tick 12
    do_fire(7, 0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 11) begin
        probe("b_t11_on", 320, 304, 1'b1, 1'b1, 12'h48F);
        probe("b_t11_off", 320, 303, 1'b1, 1'b0, 12'h000);
      end
    end
    probe("b_300", 320, 300, 1'b1, 1'b1, 12'h48F);
    probe("b_295", 320, 295, 1'b1, 1'b1, 12'h48F);
    probe("b_294", 320, 294, 1'b1, 1'b0, 12'h000);
    probe("b_290", 320, 290, 1'b1, 1'b0, 12'h000);
    tick();
    probe("b_hold_stay", 320, 295, 1'b1, 1'b1, FLASH ? 12'hFFF : 12'h48F);
    rst = 1'b1;
    probe("b_rst", 5, 5, 1'b0, 1'b0, 12'h000);
    rst = 1'b0;

    // quadrant 2 into a quadrant 0 instance: busy but never visible
    do_fire(0, 2, 1'b0);
    probe("c_frame0", 5, 5, 1'b1, 1'b0, 12'h000);
    probe("c_beam0", 320, 470, 1'b1, 1'b0, 12'h000);
    for (int i = 1; i <= 18; i++) begin
      tick();
      probe("c_frame", 5, 5, (i < 18), 1'b0, 12'h000);
      probe("c_beam", 320, 470, (i < 18), 1'b0, 12'h000);
    end

    // fire together with tick, ignored refire, reset in HOLD, fresh restart
    do_fire(0, 0, 1'b1);
    probe("d_same", 320, 450, 1'b1, 1'b0, 12'h000);
    tick();
    do_fire(5, 1, 1'b0);
    probe("d_ign_quad", 5, 5, 1'b1, 1'b1, 12'h48F);
    for (int k = 2; k <= 5; k++) tick();
    probe("d_400", 320, 400, 1'b1, 1'b1, 12'h48F);
    probe("d_399", 320, 399, 1'b1, 0, 12'h000);
    tick();
    probe("d_hold_399", 320, 399, 1'b1, 1'b0, 12'h000);
    rst = 1'b1;
    probe("d_rst", 5, 5, 1'b0, 1'b0, 12'h000);
    rst = 1'b0;
    do_fire(0, 0, 1'b0);
    probe("d_fresh", 320, 450, 1'b1, 1'b0, 12'h000);
    probe("d_fresh_frame", 5, 5, 1'b1, 1'b1, 12'h48F);
    tick();
    tick();
    probe("d_fresh_head", 320, 448, 1'b1, 1'b1, 12'h48F);
    probe("d_fresh_off", 320, 447, 1'b1, 1'b0, 12'h000);

    @(posedge clk); #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
